// File: rtl/stack_arbiter.sv
// Round-robin arbiter in front of an external LIFO stack: grants one requester per cycle,
// issues push/pop strobes, tracks occupancy, and can drain the stack with a flush.
module stack_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(N),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       op,
  input  logic [N*WIDTH-1:0] wdata,
  input  logic               flush_req,
  output logic [N-1:0]       gnt,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [WIDTH-1:0]   resp_data,
  output logic               resp_err,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [WIDTH-1:0]   stk_din,
  input  logic [WIDTH-1:0]   stk_dout
);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_r, next_state_s;
  logic [IDW-1:0]   ptr_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             resp_valid_r, resp_err_r, resp_pop_r;
  logic [IDW-1:0]   resp_id_r;

  logic             any_gnt_s;
  logic [IDW-1:0]   gidx_s;
  logic [N-1:0]     gnt_s;
  logic             push_s, pop_s, good_pop_s, err_s;
  logic [WIDTH-1:0] din_s;

  // Next-state, round-robin search and stack command decode
  always_comb begin
    next_state_s = state_r;
    count_nxt_s  = count_r;
    any_gnt_s    = 1'b0;
    gidx_s       = '0;
    gnt_s        = '0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    good_pop_s   = 1'b0;
    err_s        = 1'b0;
    din_s        = '0;
    case (state_r)
      RUN: begin
        if (flush_req) begin
          if (count_r != '0) begin
            next_state_s = FLUSH;
          end else begin
            next_state_s = RUN;
          end
        end else if (|req) begin
          // search starts one past the last winner
          for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr_r) + k) % N]) begin
              any_gnt_s = 1'b1;
              gidx_s    = IDW'((int'(ptr_r) + k) % N);
            end else begin
              any_gnt_s = any_gnt_s;
            end
          end
          gnt_s[gidx_s] = 1'b1;
          if (!op[gidx_s]) begin
            if (count_r < CW'(DEPTH)) begin
              push_s      = 1'b1;
              din_s       = wdata[int'(gidx_s)*WIDTH +: WIDTH];
              count_nxt_s = count_r + CW'(1);
            end else begin
              err_s = 1'b1;
            end
          end else begin
            if (count_r != '0) begin
              pop_s       = 1'b1;
              good_pop_s  = 1'b1;
              count_nxt_s = count_r - CW'(1);
            end else begin
              err_s = 1'b1;
            end
          end
        end else begin
          next_state_s = RUN;
        end
      end
      FLUSH: begin
        if (count_r != '0) begin
          pop_s       = 1'b1;
          count_nxt_s = count_r - CW'(1);
          if (count_r == CW'(1)) begin
            next_state_s = RUN;
          end else begin
            next_state_s = FLUSH;
          end
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = RUN;
      end
    endcase
  end

  // State, pointer, occupancy and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      ptr_r        <= '0;
      count_r      <= '0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_err_r   <= 1'b0;
      resp_pop_r   <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      count_r      <= count_nxt_s;
      resp_valid_r <= any_gnt_s;
      resp_id_r    <= gidx_s;
      resp_err_r   <= err_s;
      resp_pop_r   <= good_pop_s;
      if (any_gnt_s) begin
        ptr_r <= IDW'((int'(gidx_s) + 1) % N);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Outputs forced quiet while reset is held so a pending response is dropped
  always_comb begin
    gnt        = rst ? '0 : gnt_s;
    stk_push   = push_s & ~rst;
    stk_pop    = pop_s & ~rst;
    stk_din    = rst ? '0 : din_s;
    busy       = (state_r == FLUSH) & ~rst;
    count      = rst ? '0 : count_r;
    resp_valid = resp_valid_r & ~rst;
    resp_id    = (rst || !resp_valid_r) ? '0 : resp_id_r;
    resp_err   = resp_err_r & resp_valid_r & ~rst;
    resp_data  = (resp_valid_r && resp_pop_r && !rst) ? stk_dout : '0;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter: N, 4, number of requesters.
REQ-002 Parameter: DEPTH, 8, capacity of the attached stack in entries.
REQ-003 Parameter: WIDTH, 8, data width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  per-requester request; held high until granted.
REQ-007 op  input  N  per-requester operation; 0 = push, 1 = pop.
REQ-008 wdata  input  N*WIDTH  packed push data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 flush_req  input  1  single-cycle request to empty the stack.
REQ-010 gnt  output  N  one-hot grant, combinational, at most one bit high per cycle.
REQ-011 resp_valid  output  1  registered response strobe.
REQ-012 resp_id  output  $clog2(N)  index of the requester owning the response.
REQ-013 resp_data  output  WIDTH  popped data; 0 for pushes and errors.
REQ-014 resp_err  output  1  operation rejected (push at full or pop at empty).
REQ-015 busy  output  1  high while in FLUSH.
REQ-016 count  output  $clog2(DEPTH+1)  current stack occupancy, 0..DEPTH.
REQ-017 stk_push, stk_pop  output  1 each  stack command strobes, never both high.
REQ-018 stk_din  output  WIDTH  push data to stack.
REQ-019 stk_dout  input  WIDTH  stack registered pop data, valid the cycle after stk_pop.

Function
REQ-020 FSM states RUN and FLUSH; the block SHALL enter RUN on reset.
REQ-021 In RUN, when no flush_req is present and any req bit is high, the block SHALL grant exactly one requester in the same cycle.
REQ-022 Arbitration SHALL be round-robin: the search starts at last_granted+1 modulo N; after reset it starts at requester 0; the pointer updates only on a grant.
REQ-023 Granted push with count<DEPTH: stk_push=1, stk_din=granted wdata, count+1 at the next edge.
REQ-024 Granted pop with count>0: stk_pop=1, count-1 at the next edge.
REQ-025 Granted push at count==DEPTH or pop at count==0: no stack strobe, count unchanged, and resp_err=1 on the response.
REQ-026 Every grant in cycle T SHALL produce exactly one response in cycle T+1: resp_valid=1, resp_id=granted index, resp_data=stk_dout for a good pop and 0 otherwise.
REQ-027 resp_valid SHALL be 0 in any cycle not preceded by a grant; throughput is one operation per cycle, back-to-back.
REQ-028 flush_req in RUN with count>0: no grant that cycle; the FSM SHALL enter FLUSH at the next edge.
REQ-029 flush_req in RUN with count==0: no grant that cycle, and the FSM stays in RUN.
REQ-030 In FLUSH: busy=1, gnt=0, stk_pop=1 every cycle, count-1 per edge, and no response generated.
REQ-031 The FSM SHALL return to RUN on the edge at which count reaches 0; requests are accepted the following cycle.
REQ-032 flush_req received while in FLUSH SHALL be ignored.
REQ-033 A response owed from cycle T SHALL still be delivered in T+1 even if flush starts in cycle T+1.
REQ-034 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-035 On rst: gnt=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0, count=0, stk_push=0, stk_pop=0, stk_din=0, state=RUN, RR pointer=requester 0.
REQ-036 Any response pending at reset SHALL be dropped.
REQ-037 The attached stack SHALL share the same rst so that occupancy stays consistent with count.

Verification
REQ-038 Reset, then req=4'b1111 with op=0 held 4 cycles -> gnt sequence 0001, 0010, 0100, 1000; responses id 0..3 with err=0; count=4.
REQ-039 Push 0xA1, 0xB2, 0xC3 from requester 0, then pop from requester 2 three times -> resp_data 0xC3, 0xB2, 0xA1 (LIFO order), each one cycle after gnt, id=2.
REQ-040 Fill to count=8, push from requester 1 -> resp_err=1, count stays 8, no stk_push; pop at count=0 -> resp_err=1, resp_data=0.
REQ-041 count=5, pulse flush_req while req=4'b0011 -> no grant that cycle; busy high 5 cycles with stk_pop each; count=0; RUN; grant resumes in the next cycle.
REQ-042 Assert rst mid-burst with count=3 and a pop granted the previous cycle -> no resp_valid; all outputs 0; next grant goes to requester 0.
